fp_exec_result_pipe: RTL and testbench
======================================

Name: fp_exec_result_pipe

Overview:
Parametrised multi-lane, multi-stage result pipeline between FP execution units and the FP register-write stage. Generalises the single fixed FP_ISSUE_WIDTH pipeline register to LANES lanes × DEPTH stages. Adds a global stall, selective flush by wrap-aware age tag, and an occupancy counter. Sits at the tail of the FP back-end and feeds register-write and bypass.

Parameters:
LANES, 2, number of parallel FP result lanes (≥1)
DEPTH, 3, register stages per lane = latency in cycles (≥1)
DATA_WIDTH, 64, result data width
TAG_WIDTH, 7, active-list age tag width; modular, wrap-aware
DST_WIDTH, 7, physical destination register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold every stage; inputs not captured
flush  in  1  selective flush request
flushTag  in  TAG_WIDTH  kill entries strictly younger than this tag
inValid  in  LANES  per-lane input valid
inTag  in  LANES*TAG_WIDTH  per-lane age tag
inDst  in  LANES*DST_WIDTH  per-lane destination index
inData  in  LANES*DATA_WIDTH  per-lane result
outValid  out  LANES  last-stage valid (registered)
outTag  out  LANES*TAG_WIDTH  last-stage tag
outDst  out  LANES*DST_WIDTH  last-stage destination
outData  out  LANES*DATA_WIDTH  last-stage data
occupancy  out  $clog2(LANES*DEPTH+1)  count of valid entries in all stages (registered)

Behaviour:
- Reset: all stage valid bits, tags, dst, data = 0; outValid = 0; occupancy = 0. Reset overrides stall and flush in the same cycle. Reset mid-operation discards all in-flight entries.
- Younger(a,f) = ((a − f) mod 2^TAG_WIDTH) in [1, 2^(TAG_WIDTH−1)−1]. Equal tag is not younger. Difference ≥ 2^(TAG_WIDTH−1) counts as older.
- No stall: stage0 ← inputs and stage k ← stage k−1 each cycle. Input at edge t appears on out* at edge t+DEPTH−1, i.e. visible for cycle t+DEPTH. Lanes are independent and never reordered.
- Stall: all stages hold their contents; in* is ignored. Upstream must hold or replay its inputs. Out* is stable. Downstream also stalls.
- Flush in cycle t: every entry (any stage, plus the input being captured at the edge) with valid=1 and Younger(tag, flushTag) has its valid cleared at the end of t. Out* during cycle t is unaffected; the downstream stage handles same-cycle kills.
- Stall and flush together: entries hold in place, and matching entries are invalidated in place.
- Invalid entries: data/tag/dst are don't-care, but must still be registered (no X propagation at reset).
- occupancy = popcount of next-state valid bits across LANES×DEPTH, registered. It therefore equals the valid count visible in the cycle after the edge. Max LANES*DEPTH; no overflow possible.
- DEPTH=1: single register stage; all rules apply unchanged.

Optional Feature:
RSD_FP_RESULT_PIPE_PERF_EN
- Defined: adds outputs perfStallCycles (32b) and perfFlushKills (32b).
  - perfStallCycles increments each cycle with stall=1 and occupancy>0.
  - perfFlushKills adds the number of valid entries killed by flush that cycle.
  - Both saturate at 2^32−1 and reset to 0 on rst.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package FPPipeTypes:
  - typedef FPResultPipeEntry {valid, tag, dst, data}
  - function IsYounger(tag, flushTag)
  - localparam for the occupancy width
- Natural sub-module fp_result_pipe_lane: one lane of DEPTH stages with stall/flush, exporting per-stage valid bits. The top instantiates LANES copies, sums valid bits for occupancy, and hosts the perf counters.

Test Plan:
- Reset/latency: LANES=2, DEPTH=3; after rst, inject lane0 tag=5 data=0xA at cycle 0 → outValid[0]=1, outData=0xA in cycle 3; occupancy 1,1,1 then 0.
- Stall: inject tags 1,2,3 back-to-back, stall for 4 cycles from cycle 2 → outputs frozen 4 cycles; order 1,2,3 preserved; occupancy holds at 3.
- Selective flush: pipe holds tags 10,11,12; flush with flushTag=10 → tags 11 and 12 invalidated; tag 10 emerges; occupancy drops 3→1.
- Wrap: TAG_WIDTH=7, pipe holds tags 126,127,0,1; flushTag=127 → tags 0 and 1 killed, 126 and 127 survive.
- Stall+flush+input together: stall=1, flush=1, inValid=1 with a young tag → held young entries killed, input not captured, next-cycle occupancy correct.
- Perf (macro defined): 5 stall cycles with occupancy>0 plus 3 flush kills → perfStallCycles=5, perfFlushKills=3; rst → both 0.

Source files
------------

// File: rtl/fp_exec_result_pipe_pkg.sv
// Shared types and helpers for the FP execution result pipeline.
// Tags are modular active-list ages; IsYounger implements the wrap-aware comparison.
package FPPipeTypes;

    localparam int FP_LANES      = 2;
    localparam int FP_DEPTH      = 3;
    localparam int FP_DATA_WIDTH = 64;
    localparam int FP_TAG_WIDTH  = 7;
    localparam int FP_DST_WIDTH  = 7;
    localparam int FP_OCC_WIDTH  = $clog2(FP_LANES * FP_DEPTH + 1);

    typedef struct packed {
        logic                     valid;
        logic [FP_TAG_WIDTH-1:0]  tag;
        logic [FP_DST_WIDTH-1:0]  dst;
        logic [FP_DATA_WIDTH-1:0] data;
    } FPResultPipeEntry;

    function automatic int OccupancyWidth(input int lanes, input int depth);
        return $clog2(lanes * depth + 1);
    endfunction

    // Younger when the modular distance from flushTag lies in the lower half, excluding zero.
    function automatic logic IsYounger(input logic [31:0] tag, input logic [31:0] flushTag,
                                       input int tagWidth);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (32'h1 << tagWidth) - 32'h1;
        diff = (tag - flushTag) & mask;
        return (diff != 32'h0) && (diff < (32'h1 << (tagWidth - 1)));
    endfunction

endpackage

// File: rtl/fp_exec_result_pipe_lane.sv
// One result lane: DEPTH register stages with global stall and tag-based selective flush.
// Exports next-state valid bits (and, with RSD_FP_RESULT_PIPE_PERF_EN, per-stage kill bits).
module fp_result_pipe_lane
    import FPPipeTypes::*;
#(
    parameter int DEPTH      = 3,
    parameter int TAG_WIDTH  = 7,
    parameter int DST_WIDTH  = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [TAG_WIDTH-1:0]  flush_tag,
    input  logic                  in_valid,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [DST_WIDTH-1:0]  in_dst,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [DST_WIDTH-1:0]  out_dst,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DEPTH-1:0]      valid_next
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    ,
    output logic [DEPTH-1:0]      killed
`endif
);

    logic [DEPTH-1:0]      valid_reg;
    logic [DEPTH-1:0]      src_valid;
    logic [DEPTH-1:0]      cand_valid;
    logic [DEPTH-1:0]      kill;
    logic [TAG_WIDTH-1:0]  tag_reg  [DEPTH];
    logic [TAG_WIDTH-1:0]  src_tag  [DEPTH];
    logic [TAG_WIDTH-1:0]  cand_tag [DEPTH];
    logic [DST_WIDTH-1:0]  dst_reg  [DEPTH];
    logic [DST_WIDTH-1:0]  src_dst  [DEPTH];
    logic [DATA_WIDTH-1:0] data_reg [DEPTH];
    logic [DATA_WIDTH-1:0] src_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid;
            assign src_tag[gi]   = in_tag;
            assign src_dst[gi]   = in_dst;
            assign src_data[gi]  = in_data;
        end else begin : g_body
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_tag[gi]   = tag_reg[gi-1];
            assign src_dst[gi]   = dst_reg[gi-1];
            assign src_data[gi]  = data_reg[gi-1];
        end
        // The flush candidate is whatever would occupy this stage after the edge.
        assign cand_valid[gi] = stall ? valid_reg[gi] : src_valid[gi];
        assign cand_tag[gi]   = stall ? tag_reg[gi]   : src_tag[gi];
        assign kill[gi]       = cand_valid[gi] & flush
                              & IsYounger(32'(cand_tag[gi]), 32'(flush_tag), TAG_WIDTH);
        assign valid_next[gi] = cand_valid[gi] & ~kill[gi];
    end

`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    assign killed = kill;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_reg[k]  <= '0;
                dst_reg[k]  <= '0;
                data_reg[k] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            if (!stall) begin
                for (int k = 0; k < DEPTH; k++) begin
                    tag_reg[k]  <= src_tag[k];
                    dst_reg[k]  <= src_dst[k];
                    data_reg[k] <= src_data[k];
                end
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_tag   = tag_reg[DEPTH-1];
    assign out_dst   = dst_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/fp_exec_result_pipe.sv
// LANES x DEPTH FP result pipeline with stall, selective flush and occupancy count.
// Define RSD_FP_RESULT_PIPE_PERF_EN to add saturating stall-cycle and flush-kill counters.
module fp_exec_result_pipe
    import FPPipeTypes::*;
#(
    parameter int LANES      = 2,
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 7,
    parameter int DST_WIDTH  = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic [TAG_WIDTH-1:0]                  flushTag,
    input  logic [LANES-1:0]                      inValid,
    input  logic [LANES*TAG_WIDTH-1:0]            inTag,
    input  logic [LANES*DST_WIDTH-1:0]            inDst,
    input  logic [LANES*DATA_WIDTH-1:0]           inData,
    output logic [LANES-1:0]                      outValid,
    output logic [LANES*TAG_WIDTH-1:0]            outTag,
    output logic [LANES*DST_WIDTH-1:0]            outDst,
    output logic [LANES*DATA_WIDTH-1:0]           outData,
    output logic [$clog2(LANES*DEPTH+1)-1:0]      occupancy
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    ,
    output logic [31:0]                           perfStallCycles,
    output logic [31:0]                           perfFlushKills
`endif
);

    localparam int OCC_W = OccupancyWidth(LANES, DEPTH);

    logic [DEPTH-1:0] lane_valid_next [LANES];
    logic [OCC_W-1:0] occ_next;
    logic [OCC_W-1:0] occupancy_reg;

`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    logic [DEPTH-1:0] lane_killed [LANES];
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        fp_result_pipe_lane #(
            .DEPTH      (DEPTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .DST_WIDTH  (DST_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .stall      (stall),
            .flush      (flush),
            .flush_tag  (flushTag),
            .in_valid   (inValid[gi]),
            .in_tag     (inTag[gi*TAG_WIDTH +: TAG_WIDTH]),
            .in_dst     (inDst[gi*DST_WIDTH +: DST_WIDTH]),
            .in_data    (inData[gi*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid  (outValid[gi]),
            .out_tag    (outTag[gi*TAG_WIDTH +: TAG_WIDTH]),
            .out_dst    (outDst[gi*DST_WIDTH +: DST_WIDTH]),
            .out_data   (outData[gi*DATA_WIDTH +: DATA_WIDTH]),
            .valid_next (lane_valid_next[gi])
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
            ,
            .killed     (lane_killed[gi])
`endif
        );
    end

    always_comb begin
        occ_next = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
                occ_next = occ_next + OCC_W'(lane_valid_next[l][k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occ_next;
        end
    end

    assign occupancy = occupancy_reg;

`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    logic [OCC_W-1:0] kill_count;
    logic [32:0]      kills_sum;
    logic [31:0]      perf_stall_reg;
    logic [31:0]      perf_kills_reg;

    always_comb begin
        kill_count = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
                kill_count = kill_count + OCC_W'(lane_killed[l][k]);
            end
        end
    end

    assign kills_sum = {1'b0, perf_kills_reg} + 33'(kill_count);

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_kills_reg <= '0;
        end else begin
            if (stall && (occupancy_reg != '0) && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            perf_kills_reg <= kills_sum[32] ? '1 : kills_sum[31:0];
        end
    end

    assign perfStallCycles = perf_stall_reg;
    assign perfFlushKills  = perf_kills_reg;
`endif

endmodule

// File: tb/tb_fp_exec_result_pipe.sv
// Self-checking bench: slot-list model of the pipe compared every cycle, plus directed literal checks.
module tb_fp_exec_result_pipe;

    localparam int LANES = 2;
    localparam int DEPTH = 3;
    localparam int DW    = 64;
    localparam int TW    = 7;
    localparam int SW    = 7;
    localparam int OCC_W = $clog2(LANES*DEPTH+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, stall, flush;
    logic [TW-1:0]       flushTag;
    logic [LANES-1:0]    inValid;
    logic [LANES*TW-1:0] inTag;
    logic [LANES*SW-1:0] inDst;
    logic [LANES*DW-1:0] inData;
    logic [LANES-1:0]    outValid;
    logic [LANES*TW-1:0] outTag;
    logic [LANES*SW-1:0] outDst;
    logic [LANES*DW-1:0] outData;
    logic [OCC_W-1:0]    occupancy;
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
    logic [31:0]         perfStallCycles, perfFlushKills;
`endif

    fp_exec_result_pipe #(
        .LANES(LANES), .DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DST_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flushTag(flushTag),
        .inValid(inValid), .inTag(inTag), .inDst(inDst), .inData(inData),
        .outValid(outValid), .outTag(outTag), .outDst(outDst), .outData(outData),
        .occupancy(occupancy)
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
        , .perfStallCycles(perfStallCycles), .perfFlushKills(perfFlushKills)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit younger(input logic [TW-1:0] a, input logic [TW-1:0] f);
        int d;
        d = (int'(a) - int'(f) + (1 << TW)) % (1 << TW);
        return (d >= 1) && (d <= (1 << (TW-1)) - 1);
    endfunction

    // Model: each lane is a list of DEPTH slots, slot DEPTH-1 being the visible output.
    bit            m_v [LANES][DEPTH];
    logic [TW-1:0] m_t [LANES][DEPTH];
    logic [SW-1:0] m_s [LANES][DEPTH];
    logic [DW-1:0] m_d [LANES][DEPTH];
    int            m_occ = 0;
    longint        m_stall_cnt = 0;
    longint        m_kill_cnt = 0;
    bit            ready = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < DEPTH; k++) begin
                    m_v[l][k] = 0; m_t[l][k] = '0; m_s[l][k] = '0; m_d[l][k] = '0;
                end
            m_occ = 0; m_stall_cnt = 0; m_kill_cnt = 0; ready = 1;
        end else begin
            if (stall && m_occ > 0) m_stall_cnt++;
            for (int l = 0; l < LANES; l++) begin
                if (!stall) begin
                    for (int k = DEPTH-1; k > 0; k--) begin
                        m_v[l][k] = m_v[l][k-1]; m_t[l][k] = m_t[l][k-1];
                        m_s[l][k] = m_s[l][k-1]; m_d[l][k] = m_d[l][k-1];
                    end
                    m_v[l][0] = inValid[l];
                    m_t[l][0] = inTag[l*TW +: TW];
                    m_s[l][0] = inDst[l*SW +: SW];
                    m_d[l][0] = inData[l*DW +: DW];
                end
                for (int k = 0; k < DEPTH; k++)
                    if (flush && m_v[l][k] && younger(m_t[l][k], flushTag)) begin
                        m_v[l][k] = 0;
                        m_kill_cnt++;
                    end
            end
            m_occ = 0;
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < DEPTH; k++) m_occ += int'(m_v[l][k]);
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            for (int l = 0; l < LANES; l++) begin
                chk("model_outValid", 64'(outValid[l]), 64'(m_v[l][DEPTH-1]));
                if (m_v[l][DEPTH-1]) begin
                    chk("model_outTag", 64'(outTag[l*TW +: TW]), 64'(m_t[l][DEPTH-1]));
                    chk("model_outDst", 64'(outDst[l*SW +: SW]), 64'(m_s[l][DEPTH-1]));
                    chk("model_outData", outData[l*DW +: DW], m_d[l][DEPTH-1]);
                end
            end
            chk("model_occupancy", 64'(occupancy), 64'(m_occ));
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
            chk("model_perfStall", 64'(perfStallCycles), 64'(m_stall_cnt));
            chk("model_perfKills", 64'(perfFlushKills), 64'(m_kill_cnt));
`endif
        end
    end

    task automatic put(input int l, input logic [TW-1:0] t, input logic [DW-1:0] d);
        inValid[l]        = 1'b1;
        inTag[l*TW +: TW] = t;
        inDst[l*SW +: SW] = t ^ 7'h2A;
        inData[l*DW +: DW] = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; flushTag = '0;
        inValid = '0; inTag = '0; inDst = '0; inData = '0;
        repeat (2) step();
        chk("rst_outValid", 64'(outValid), 64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        rst = 0;

        // Latency: tag 5 captured at edge 0, visible after edge 2.
        put(0, 7'd5, 64'hA); step(); inValid = '0;
        chk("lat_occ0", 64'(occupancy), 64'd1);
        chk("lat_v0", 64'(outValid), 64'h0);
        step();
        chk("lat_occ1", 64'(occupancy), 64'd1);
        step();
        chk("lat_v2", 64'(outValid), 64'h1);
        chk("lat_data2", outData[DW-1:0], 64'hA);
        chk("lat_tag2", 64'(outTag[TW-1:0]), 64'd5);
        chk("lat_occ2", 64'(occupancy), 64'd1);
        step();
        chk("lat_v3", 64'(outValid), 64'h0);
        chk("lat_occ3", 64'(occupancy), 64'd0);

        // Stall: out frozen on tag 1 while a garbage input is offered.
        put(0, 7'd1, 64'h101); step();
        put(0, 7'd2, 64'h102); step();
        put(0, 7'd3, 64'h103); step();
        chk("stall_pre_tag", 64'(outTag[TW-1:0]), 64'd1);
        stall = 1; put(0, 7'd99, 64'hBAD);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_tag", 64'(outTag[TW-1:0]), 64'd1);
            chk("stall_occ", 64'(occupancy), 64'd3);
        end
        stall = 0; inValid = '0;
        step(); chk("unstall_tag2", 64'(outTag[TW-1:0]), 64'd2); chk("unstall_occ2", 64'(occupancy), 64'd2);
        step(); chk("unstall_tag3", 64'(outTag[TW-1:0]), 64'd3); chk("unstall_occ1", 64'(occupancy), 64'd1);
        step(); chk("unstall_empty", 64'(outValid), 64'h0);

        // Selective flush on lane 1: 11 in flight and 12 being captured die, 10 survives.
        put(1, 7'd10, 64'h10); step();
        put(1, 7'd11, 64'h11); step();
        put(1, 7'd12, 64'h12); flush = 1; flushTag = 7'd10; step();
        flush = 0; inValid = '0;
        chk("flush_v", 64'(outValid), 64'h2);
        chk("flush_tag", 64'(outTag[2*TW-1:TW]), 64'd10);
        chk("flush_occ", 64'(occupancy), 64'd1);
        step(); chk("flush_occ_after", 64'(occupancy), 64'd0);

        // Wrap: flushTag 127 kills 0 and 1 but not 126 or 127.
        put(0, 7'd126, 64'h7E); step();
        put(0, 7'd127, 64'h7F); step();
        put(0, 7'd0, 64'h80); step();
        chk("wrap_pre_tag", 64'(outTag[TW-1:0]), 64'd126);
        put(0, 7'd1, 64'h81); flush = 1; flushTag = 7'd127; step();
        flush = 0; inValid = '0;
        chk("wrap_tag", 64'(outTag[TW-1:0]), 64'd127);
        chk("wrap_v", 64'(outValid), 64'h1);
        chk("wrap_occ", 64'(occupancy), 64'd1);
        step(); chk("wrap_occ_after", 64'(occupancy), 64'd0);

        // Stall + flush + input: held 21,22 killed in place, input 30 ignored.
        put(0, 7'd20, 64'h20); step();
        put(0, 7'd21, 64'h21); step();
        put(0, 7'd22, 64'h22); step();
        stall = 1; flush = 1; flushTag = 7'd20; put(0, 7'd30, 64'h30); step();
        stall = 0; flush = 0; inValid = '0;
        chk("sf_occ", 64'(occupancy), 64'd1);
        chk("sf_tag", 64'(outTag[TW-1:0]), 64'd20);
        chk("sf_v", 64'(outValid), 64'h1);
        step(); chk("sf_occ_after", 64'(occupancy), 64'd0);
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
        chk("perf_stall", 64'(perfStallCycles), 64'd5);
        chk("perf_kills", 64'(perfFlushKills), 64'd6);
`endif

        // Lane independence: same-cycle flush keeps lane 0 tag 50, kills lane 1 tag 51.
        put(0, 7'd50, 64'h50); put(1, 7'd51, 64'h51); flush = 1; flushTag = 7'd50; step();
        flush = 0; inValid = '0;
        chk("lanes_occ", 64'(occupancy), 64'd1);
        step(); step();
        chk("lanes_v", 64'(outValid), 64'h1);
        chk("lanes_tag", 64'(outTag[TW-1:0]), 64'd50);
        step();

        // Mid-operation reset discards in-flight entries.
        put(1, 7'd40, 64'h40); step(); inValid = '0;
        chk("mid_occ", 64'(occupancy), 64'd1);
        rst = 1; step(); rst = 0;
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_v", 64'(outValid), 64'h0);
`ifdef RSD_FP_RESULT_PIPE_PERF_EN
        chk("perf_rst_stall", 64'(perfStallCycles), 64'd0);
        chk("perf_rst_kills", 64'(perfFlushKills), 64'd0);
`endif
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
